// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO used as an elastic buffer between datapath
//   stages. Supports simultaneous read+write, exact occupancy count,
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags and
//   a synchronous flush.
//
//   Build option: FIFO_FWFT_EN
//     defined   - first-word fall-through: dataOut shows the head word
//                 combinationally, VALID = !EMPTY, RD pops the shown word.
//     undefined - standard mode: one-cycle registered read; dataOut/VALID
//                 update the cycle after an accepted read.
//
// Ports
//   Clk           clock, rising edge
//   Rst_n         asynchronous active-low reset
//   EN            global enable (0 = hold all state)
//   Clr           synchronous flush, qualified by EN, priority over RD/WR
//   WR / dataIn   write request / write data
//   RD            read request (pop)
//   dataOut       read data
//   VALID         dataOut holds a valid word
//   EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL   registered occupancy flags
//   Count         occupancy, 0..DEPTH
//   OVF / UDF     sticky overflow / underflow
// ----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     EN,
    input  logic                     Clr,
    input  logic                     WR,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     RD,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     VALID,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ALMOST_FULL,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     OVF,
    output logic                     UDF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          empty_q,  empty_d;
    logic          full_q,   full_d;
    logic          ae_q,     ae_d;
    logic          af_q,     af_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;

    logic          clr_go;
    logic          rd_ok;
    logic          wr_ok;
    logic [WIDTH-1:0] head_word;

    // Accept logic. A write into a full FIFO is allowed when a read frees a
    // slot in the same cycle; flush suppresses both operations and all flags.
    always_comb begin
        clr_go = EN & Clr;
        rd_ok  = EN & ~Clr & RD & ~empty_q;
        wr_ok  = EN & ~Clr & WR & (~full_q | rd_ok);

        if (clr_go) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + CW'(wr_ok);
            rd_ptr_d = rd_ptr_q + CW'(rd_ok);
        end

        // Wrap bit makes the difference exact across 0..DEPTH.
        count_d = wr_ptr_d - rd_ptr_d;

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_LEVEL);
        ae_d    = (count_d <= AE_LEVEL);
        af_d    = (count_d >= AF_LEVEL);

        if (clr_go) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (EN & WR & full_q & ~rd_ok);
            udf_d = udf_q | (EN & RD & empty_q);
        end

        head_word = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= dataIn;
        end
    end

`ifdef FIFO_FWFT_EN
    assign dataOut = head_word;
    assign VALID   = ~empty_q;
`else
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;

    // VALID pulses for exactly one cycle per accepted read; dataOut holds.
    always_comb begin
        dout_d  = dout_q;
        valid_d = rd_ok;
        if (clr_go) begin
            dout_d = '0;
        end else if (rd_ok) begin
            dout_d = head_word;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dataOut = dout_q;
    assign VALID   = valid_q;
`endif

    assign EMPTY        = empty_q;
    assign FULL         = full_q;
    assign ALMOST_EMPTY = ae_q;
    assign ALMOST_FULL  = af_q;
    assign Count        = count_q;
    assign OVF          = ovf_q;
    assign UDF          = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed bench for sync_fifo_param (WIDTH=32, DEPTH=8, margins=1).
//   Works in both standard and FIFO_FWFT_EN builds.
// ----------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic        Clk;
    logic        Rst_n;
    logic        EN;
    logic        Clr;
    logic        WR;
    logic [31:0] dataIn;
    logic        RD;
    logic [31:0] dataOut;
    logic        VALID;
    logic        EMPTY;
    logic        FULL;
    logic        ALMOST_EMPTY;
    logic        ALMOST_FULL;
    logic [3:0]  Count;
    logic        OVF;
    logic        UDF;

    int unsigned n_tests;
    int unsigned n_fail;

    sync_fifo_param #(
        .WIDTH     (32),
        .DEPTH     (8),
        .AF_MARGIN (1),
        .AE_MARGIN (1)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .EN           (EN),
        .Clr          (Clr),
        .WR           (WR),
        .dataIn       (dataIn),
        .RD           (RD),
        .dataOut      (dataOut),
        .VALID        (VALID),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .Count        (Count),
        .OVF          (OVF),
        .UDF          (UDF)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        WR     = 1'b1;
        dataIn = d;
        tick();
        WR     = 1'b0;
    endtask

    task automatic pop(input logic [31:0] exp, input string tag);
`ifdef FIFO_FWFT_EN
        check_eq({tag, "_valid"}, 64'(VALID), 64'd1);
        check_eq({tag, "_data"}, 64'(dataOut), 64'(exp));
        RD = 1'b1;
        tick();
        RD = 1'b0;
`else
        RD = 1'b1;
        tick();
        RD = 1'b0;
        check_eq({tag, "_valid"}, 64'(VALID), 64'd1);
        check_eq({tag, "_data"}, 64'(dataOut), 64'(exp));
`endif
    endtask

    task automatic check_flags(input string tag, input logic [3:0] cnt,
                               input logic ovf, input logic udf);
        check_eq({tag, "_count"}, 64'(Count), 64'(cnt));
        check_eq({tag, "_empty"}, 64'(EMPTY), 64'(cnt == 4'd0));
        check_eq({tag, "_full"},  64'(FULL),  64'(cnt == 4'd8));
        check_eq({tag, "_ae"},    64'(ALMOST_EMPTY), 64'(cnt <= 4'd1));
        check_eq({tag, "_af"},    64'(ALMOST_FULL),  64'(cnt >= 4'd7));
        check_eq({tag, "_ovf"},   64'(OVF), 64'(ovf));
        check_eq({tag, "_udf"},   64'(UDF), 64'(udf));
    endtask

    initial begin
        logic exp_valid;
        n_tests = 0;
        n_fail  = 0;
        Rst_n   = 1'b0;
        EN      = 1'b0;
        Clr     = 1'b0;
        WR      = 1'b0;
        RD      = 1'b0;
        dataIn  = '0;

        // Reset state
        #12;
        check_flags("rst", 4'd0, 1'b0, 1'b0);
        check_eq("rst_valid", 64'(VALID), 64'd0);
`ifndef FIFO_FWFT_EN
        check_eq("rst_dout", 64'(dataOut), 64'd0);
`endif
        Rst_n = 1'b1;
        EN    = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of traffic
        push(32'hDEAD_0001);
        push(32'hDEAD_0002);
        WR     = 1'b1;
        RD     = 1'b1;
        dataIn = 32'hDEAD_0003;
        tick();
        check_eq("t1_pre_count", 64'(Count), 64'd2);
        #2;
        Rst_n = 1'b0;
        #1;
        check_flags("t1_rst", 4'd0, 1'b0, 1'b0);
        check_eq("t1_rst_valid", 64'(VALID), 64'd0);
        WR = 1'b0;
        RD = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();

        // 2: fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            push(32'(i));
            check_flags($sformatf("t2_fill%0d", i), 4'(i + 1), 1'b0, 1'b0);
        end
        push(32'h0000_0009);
        check_flags("t2_ovf", 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop(32'(i), $sformatf("t2_drain%0d", i));
            check_eq($sformatf("t2_drain%0d_count", i), 64'(Count), 64'(7 - i));
        end
        tick();
        check_eq("t2_valid_drop", 64'(VALID), 64'd0);
        check_flags("t2_end", 4'd0, 1'b1, 1'b0);
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        check_flags("t2_clr", 4'd0, 1'b0, 1'b0);

        // 3: interleaved traffic across pointer wrap
        for (int i = 0; i < 20; i++) begin
            push(32'h100 + 32'(i));
            check_eq($sformatf("t3_empty_fall%0d", i), 64'(EMPTY), 64'd0);
            pop(32'h100 + 32'(i), $sformatf("t3_rd%0d", i));
        end
        check_flags("t3_end", 4'd0, 1'b0, 1'b0);

        // 4: simultaneous read+write at full and at empty
        for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
        check_eq("t4_full", 64'(FULL), 64'd1);
`ifdef FIFO_FWFT_EN
        check_eq("t4_rw_data", 64'(dataOut), 64'h10);
`endif
        WR     = 1'b1;
        RD     = 1'b1;
        dataIn = 32'hAA;
        tick();
        WR = 1'b0;
        RD = 1'b0;
`ifndef FIFO_FWFT_EN
        check_eq("t4_rw_data", 64'(dataOut), 64'h10);
`endif
        check_flags("t4_rw_full", 4'd8, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) pop(32'h10 + 32'(i), $sformatf("t4_drain%0d", i));
        pop(32'hAA, "t4_last");
        check_flags("t4_empty", 4'd0, 1'b0, 1'b0);
        WR     = 1'b1;
        RD     = 1'b1;
        dataIn = 32'hBB;
        tick();
        WR = 1'b0;
        RD = 1'b0;
`ifdef FIFO_FWFT_EN
        exp_valid = 1'b1;
`else
        exp_valid = 1'b0;
`endif
        check_flags("t4_rw_empty", 4'd1, 1'b0, 1'b1);
        check_eq("t4_rw_empty_valid", 64'(VALID), 64'(exp_valid));
        pop(32'hBB, "t4_bb");
        check_flags("t4_bb_end", 4'd0, 1'b0, 1'b1);

        // 5: flush with 5 entries, OVF set and RD/WR active
        for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
        push(32'h2F);
        for (int i = 0; i < 3; i++) pop(32'h20 + 32'(i), $sformatf("t5_rd%0d", i));
        check_flags("t5_pre", 4'd5, 1'b1, 1'b1);
        Clr    = 1'b1;
        WR     = 1'b1;
        RD     = 1'b1;
        dataIn = 32'h77;
        tick();
        Clr = 1'b0;
        WR  = 1'b0;
        RD  = 1'b0;
        check_flags("t5_clr", 4'd0, 1'b0, 1'b0);
        check_eq("t5_valid", 64'(VALID), 64'd0);
`ifndef FIFO_FWFT_EN
        check_eq("t5_dout", 64'(dataOut), 64'd0);
`endif

        // 6: EN=0 holds everything while RD/WR toggle
        push(32'h55);
        push(32'h66);
        EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            RD     = (i % 2) == 0;
            WR     = (i % 2) != 0;
            dataIn = 32'hC0 + 32'(i);
            tick();
            check_eq($sformatf("t6_count%0d", i), 64'(Count), 64'd2);
        end
        check_flags("t6_hold", 4'd2, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        check_eq("t6_valid", 64'(VALID), 64'd0);
        check_eq("t6_dout", 64'(dataOut), 64'd0);
`endif
        RD = 1'b0;
        WR = 1'b0;
        EN = 1'b1;
        pop(32'h55, "t6_rd0");
        pop(32'h66, "t6_rd1");
        check_flags("t6_end", 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
